// File: rtl/jtag_debug_ocimem_pkg.sv
// Shared definitions for the ocimem debug RAM block: jdo field positions, FSM states, status bits.
package jtag_debug_ocimem_pkg;

  localparam int JDO_W    = 38;
  localparam int ADDR_HI  = 33;
  localparam int ADDR_LO  = 26;
  localparam int RD_FLAG  = 17;
  localparam int WDATA_HI = 34;
  localparam int WDATA_LO = 3;

  localparam int STAT_OVERRUN = 0;
  localparam int STAT_PENDING = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_J_RD,
    ST_J_CAP,
    ST_A_RD,
    ST_A_CAP
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_RD,
    CMD_WR
  } cmd_e;

  typedef struct packed {
    cmd_e        op;
    logic [31:0] wdat;
  } cmd_t;

endpackage

// File: rtl/jtag_debug_ocimem_ram.sv
// Single-port 32-bit debug RAM with byte enables; read data appears one cycle after a read enable.
// No reset on the array so it maps onto a block RAM.
module jtag_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdat,
  output logic [31:0]       q
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we && be[i]) begin
          mem_q[addr][8*i +: 8] <= wdat[8*i +: 8];
        end
      end
      if (!we) begin
        rd_q <= mem_q[addr];
      end
    end
  end

  assign q = rd_q;

endmodule

// File: rtl/jtag_debug_ocimem.sv
// Arbitrates JTAG ocimem commands and the CPU Avalon slave onto one debug RAM; JTAG reads land on MonDReg 3 cycles after the pulse.
// Avalon RAM reads stall at least 2 cycles (JTAG always wins the port); writes and status accesses complete with no wait state when the port is free.
module jtag_debug_ocimem
  import jtag_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W:0]   address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic              debugaccess,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [31:0]       rdat_q, rdat_d;

  logic              ram_en, ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdat, ram_q;

  logic              av_rd, av_wr, av_stat, port_free, j_pend, wait_c;
  logic [31:0]       stat_dat;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:WDATA_HI+1], jdo[WDATA_LO-1:0]};

  assign av_rd     = chipselect & ~address[ADDR_W] & read;
  assign av_wr     = chipselect & ~address[ADDR_W] & write & ~read;
  assign av_stat   = chipselect & address[ADDR_W];
  assign j_pend    = (cmd_q.op != CMD_NONE);
  // J_CAP only finishes a register capture, so the RAM port is as free there as in IDLE
  assign port_free = (state_q == ST_IDLE) || (state_q == ST_J_CAP);

  always_comb begin
    stat_dat               = '0;
    stat_dat[STAT_OVERRUN] = overrun_q;
    stat_dat[STAT_PENDING] = j_pend;
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    overrun_d = overrun_q;
    mon_a_d   = mon_a_q;
    mon_d_d   = mon_d_q;
    rdat_d    = rdat_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = mon_a_q;
    ram_wdat  = cmd_q.wdat;
    wait_c    = 1'b0;

    case (state_q)
      ST_IDLE, ST_J_CAP: begin
        state_d = ST_IDLE;
        if (j_pend) begin
          ram_en = 1'b1;
          if (cmd_q.op == CMD_WR) begin
            ram_we   = 1'b1;
            ram_be   = 4'hF;
            mon_a_d  = mon_a_q + 1'b1;
            cmd_d.op = CMD_NONE;
          end else begin
            state_d = ST_J_RD;
          end
        end else if (av_rd) begin
          ram_en   = 1'b1;
          ram_addr = address[ADDR_W-1:0];
          state_d  = ST_A_RD;
        end else if (av_wr) begin
          // without debugaccess the write is acknowledged but never reaches the array
          ram_en   = debugaccess;
          ram_we   = debugaccess;
          ram_be   = byteenable;
          ram_addr = address[ADDR_W-1:0];
          ram_wdat = writedata;
        end
      end
      ST_J_RD: begin
        mon_d_d  = ram_q;
        cmd_d.op = CMD_NONE;
        state_d  = ST_J_CAP;
      end
      ST_A_RD: begin
        rdat_d  = ram_q;
        state_d = ST_A_CAP;
      end
      default: state_d = ST_IDLE;
    endcase

    if (av_rd) begin
      wait_c = (state_q != ST_A_CAP);
    end else if (av_wr) begin
      wait_c = !(port_free && !j_pend);
    end

    if (av_stat && write && writedata[0]) begin
      overrun_d = 1'b0;
    end

    // b > a > no_action; a busy slot drops the whole command
    if (take_action_ocimem_b || take_action_ocimem_a || take_no_action_ocimem_a) begin
      if (j_pend) begin
        overrun_d = 1'b1;
      end else if (take_action_ocimem_b) begin
        cmd_d.op   = CMD_WR;
        cmd_d.wdat = jdo[WDATA_HI:WDATA_LO];
      end else if (take_action_ocimem_a) begin
        mon_a_d  = jdo[ADDR_LO +: ADDR_W];
        cmd_d.op = jdo[RD_FLAG] ? CMD_RD : CMD_NONE;
      end else begin
        mon_a_d  = mon_a_q + 1'b1;
        cmd_d.op = CMD_RD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cmd_q.op   <= CMD_NONE;
      cmd_q.wdat <= '0;
      overrun_q  <= 1'b0;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      rdat_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      overrun_q <= overrun_d;
      mon_a_q   <= mon_a_d;
      mon_d_q   <= mon_d_d;
      rdat_q    <= rdat_d;
    end
  end

  jtag_debug_ocimem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (ram_be),
    .addr (ram_addr),
    .wdat (ram_wdat),
    .q    (ram_q)
  );

  assign readdata    = (av_stat && read) ? stat_dat : rdat_q;
  assign waitrequest = wait_c & reset_n;
  assign MonDReg     = mon_d_q;
  assign MonAReg     = mon_a_q;

endmodule
